// File: rtl/up_down_pkg.sv
// Shared types and the shortest-path direction decision for the up/down seek controller.
package up_down_pkg;

  typedef enum logic [1:0] {IDLE, EVAL, STEP, DONE} seek_state_t;

  // Values match the {up, down} command pair; CLR is the counter's reset code.
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    DN   = 2'b01,
    UP   = 2'b10,
    CLR  = 2'b11
  } dir_t;

  // diff is (target - count) mod 2**width. A tie at exactly half the range resolves to UP.
  function automatic dir_t seek_dir(input logic [31:0] diff, input int unsigned width);
    logic [31:0] half;
    half = 32'd1 << (width - 1);
    if (diff == 32'd0) return HOLD;
    else if (diff <= half) return UP;
    else return DN;
  endfunction

endpackage

// File: rtl/up_down_seek_ctrl.sv
// Steps an up/down counter one position per EVAL/STEP pair until its count matches a
// handshaken target, with timeout (sticky error) and abort.
module up_down_seek_ctrl
  import up_down_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16   // must be >= 2**(WIDTH-1) so any reachable target fits
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target,
  input  logic             target_valid,
  output logic             target_ready,
  input  logic             abort,
  input  logic [WIDTH-1:0] count,
  output logic             up,
  output logic             down,
  output logic             busy,
  output logic             done,
  output logic             error,
  output seek_state_t      state_dbg
);

  localparam int SW = $clog2(TIMEOUT + 1);

  // Handshake: a target is taken on any edge where target_valid && target_ready.
  // target_ready is high exactly while the FSM sits in IDLE; the host holds
  // target_valid (and target) until that edge.

  seek_state_t      state;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] diff;
  logic [SW-1:0]    steps;
  dir_t             dir;

  assign diff         = tgt - count;
  assign dir          = seek_dir(32'(diff), WIDTH);
  assign target_ready = (state == IDLE);
  assign state_dbg    = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tgt   <= '0;
      steps <= '0;
      up    <= 1'b0;
      down  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (target_valid) begin
            tgt   <= target;
            error <= 1'b0;
            steps <= '0;
            busy  <= 1'b1;
            state <= EVAL;
          end
        end
        EVAL: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (dir == HOLD) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (steps == SW'(TIMEOUT)) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= IDLE;
          end else begin
            up    <= (dir == UP);
            down  <= (dir == DN);
            state <= STEP;
          end
        end
        STEP: begin
          // The counter applies this cycle's command at the closing edge.
          up   <= 1'b0;
          down <= 1'b0;
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            steps <= steps + 1'b1;
            state <= EVAL;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_clr_code: assert property (@(posedge clk) !(up && down));

endmodule

// File: doc/up_down_seek_ctrl.md
Name: up_down_seek_ctrl

Overview:
Drives the Up/Down command inputs of the up/down counter so that its Count moves to a requested target value. It accepts a target through a valid/ready handshake, observes the counter's Count output, and steps the counter one position at a time along the shortest modular path. It signals completion, timeout or abort. It sits between a host/sequencer and the up_down_count instance, as the producer end of the Up/Down interface.

Parameters:
WIDTH, 4, width of Count and Target; counter wraps modulo 2**WIDTH.
TIMEOUT, 16, maximum Up/Down pulses issued per seek before Error is raised (must be >= 2**(WIDTH-1)).

Ports:
Clock  input  1  system clock, rising-edge active.
Reset  input  1  synchronous, active-high reset.
Target  input  WIDTH  requested count value, sampled on handshake.
TargetValid  input  1  host offers Target.
TargetReady  output  1  controller can accept a target; high only in IDLE.
Abort  input  1  cancel the current seek.
Count  input  WIDTH  current counter value, from up_down_count.
Up  output  WIDTH=1  increment command to the counter.
Down  output  1  decrement command to the counter.
Busy  output  1  a seek is in progress (EVAL or STEP).
Done  output  1  one-cycle pulse: Count equals the latched target.
Error  output  1  sticky timeout flag; cleared on the next accepted target or on Reset.

Behaviour:
- Reset (any state, mid-seek included): next edge gives state=IDLE, Up=Down=Busy=Done=Error=0, step counter=0, latched target=0. TargetReady is 1 on the first cycle after Reset deasserts.
- Up, Down, Busy and Done are registered outputs. Up and Down are never both 1; {Up,Down}=11 is the counter's reset code and is forbidden (assertion required).
- Handshake: accept occurs on an edge with TargetValid && TargetReady. It latches Target, clears Error, clears the step counter and moves to EVAL. TargetValid while not ready is ignored; the host must hold it.
- FSM states: IDLE, EVAL, STEP, DONE.
  - IDLE: TargetReady=1. Moves to EVAL on accept.
  - EVAL: compute diff = (target - Count) mod 2**WIDTH.
    - diff==0: go to DONE.
    - step counter==TIMEOUT: set Error=1 and go to IDLE. No Done pulse.
    - 0 < diff <= 2**(WIDTH-1): register Up=1 and go to STEP. A tie at exactly half the range resolves to Up.
    - Otherwise: register Down=1 and go to STEP.
  - STEP: Up or Down is high for exactly this one cycle. The counter updates at the end of this cycle. Increment the step counter, clear Up/Down, and return to EVAL.
  - DONE: Done=1 for one cycle, then IDLE.
- Timing: each step costs 2 cycles (EVAL+STEP). If the target equals Count at accept, Done is high in the 2nd cycle after the accept edge.
- Wrap-around: the shortest path crosses 0 / 2**WIDTH-1 freely; Count 15 followed by Up gives 0.
- Abort: sampled in EVAL or STEP. The next edge gives IDLE with Up=Down=0, no Done and no Error change. Abort is ignored in IDLE and DONE. Reset takes priority over Abort, and Abort takes priority over the EVAL decision.
- Count changing externally during a seek is tolerated. EVAL always re-reads the live Count.

Decomposition:
- Shared package up_down_pkg holds:
  - enum seek_state_t {IDLE, EVAL, STEP, DONE};
  - enum dir_t {HOLD=2'b00, DN=2'b01, UP=2'b10, CLR=2'b11}, matching the {Up,Down} encoding;
  - function for the modular-distance and direction decision, parameterised on WIDTH.
- No sub-module is needed. The direction/distance logic is a package function; the FSM and step counter live in the one module.

Test Plan:
- Count=5 held, accept Target=5 -> Done pulse 2 cycles after accept; Up and Down never asserted; Error=0.
- Real counter at 2, Target=5 -> exactly 3 Up pulses, 2 cycles apart; Count=5; Done 1 cycle after the last EVAL; TargetReady back high.
- Wrap cases. Count=14, Target=1 -> 3 Up pulses (15,0,1). Count=1, Target=14 -> 3 Down pulses (0,15,14). Count=0, Target=8 -> 8 Up pulses (tie case).
- Stuck Count=3 model, Target=6, TIMEOUT=16 -> 16 Up pulses, then Error=1 with no Done. A new accept with Target=3 clears Error and Done follows.
- Abort raised on the 2nd STEP of a 0->6 seek -> Up=0 on the next edge, IDLE, no Done; Count=2 on a real counter.
- Reset pulsed mid-seek while Up=1 -> all outputs 0 on the next edge; {Up,Down}=11 never observed across all tests.
